// File: rtl/ir_fetch.sv
// -----------------------------------------------------------------------------
// ir_fetch
//   Instruction fetch stage feeding the two 32-bit halves of the core
//   instruction register. Words are fetched over a req/ack memory port and
//   written into the half selected by bit 0 of the fetch word address. The
//   core's nibble pointer (pc) and decoded instruction length (cur_len) decide
//   when an instruction can issue, where pc moves to, and when a half may be
//   refilled. Branch redirects flush both halves and abandon any fetch that is
//   still in flight.
//
// Parameters
//   ADDR_W      word-address width of the memory port
//   RESET_ADDR  word address fetched first after reset
//
// Ports
//   clk            clock, all state on rising edge
//   reset          asynchronous reset, active-high
//   mem_req        fetch request
//   mem_addr       fetch word address, stable while mem_req=1
//   mem_ack        request accepted; mem_rdata valid this cycle
//   mem_rdata      fetched word
//   ir_next        {mem_rdata, mem_rdata}, written into the half(s) in ir_be
//   ir_be          one-hot IR-half write enable
//   pc             current nibble pointer from the core
//   cur_len        decoded length at pc; nibbles = cur_len+1
//   stall          execution cannot accept an instruction
//   redirect       branch taken, one-cycle pulse
//   redirect_addr  target nibble address {word, nibble[2:0]}
//   pc_next        next nibble pointer
//   pc_en          core loads pc_next
//   issue          instruction at pc consumed this cycle
//   perf_bubbles   (IR_FETCH_PERF_EN only) saturating count of cycles where
//                  execution was ready but no instruction was available
//
// Configuration
//   IR_FETCH_PERF_EN  when defined, adds the perf_bubbles port and counter.
// -----------------------------------------------------------------------------
module ir_fetch #(
  parameter int                 ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [63:0]       ir_next,
  output logic [1:0]        ir_be,
  input  logic [3:0]        pc,
  input  logic [2:0]        cur_len,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W+2:0] redirect_addr,
  output logic [3:0]        pc_next,
  output logic              pc_en,
  output logic              issue
`ifdef IR_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,  // no fetch outstanding; requests combinationally when target half is empty
    ST_REQ,   // fetch outstanding, data wanted
    ST_DROP   // fetch outstanding but made stale by a redirect
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          hv_q, hv_d;       // per-half valid flags
  logic [ADDR_W-1:0]   fa_q, fa_d;       // next word address to fetch
  logic [ADDR_W-1:0]   addr_q, addr_d;   // address presented last cycle

  // Internal (un-gated) versions of the outputs; the ports are forced to
  // their idle values while reset is asserted.
  logic              req_int;
  logic [ADDR_W-1:0] addr_int;
  logic [1:0]        be_int;
  logic [3:0]        pc_next_int;
  logic              pc_en_int;
  logic              issue_int;

  logic [3:0]        end_nib;    // pc[2:0] + length, in nibbles (1..15)
  logic              avail;
  logic              fill;
  logic [ADDR_W-1:0] redir_word;

  assign redir_word = redirect_addr[ADDR_W+2:3];

  // An instruction ending past nibble 8 of its half spills into the other
  // half, which must then also hold valid data.
  assign end_nib  = {1'b0, pc[2:0]} + {1'b0, cur_len} + 4'd1;
  assign avail    = hv_q[pc[3]] && ((end_nib <= 4'd8) || hv_q[~pc[3]]);

  assign issue_int = avail & ~stall & ~redirect;

  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case/if tree can leave one unassigned and infer a latch.
    state_d     = state_q;
    hv_d        = hv_q;
    fa_d        = fa_q;
    req_int     = 1'b0;
    addr_int    = fa_q;
    be_int      = 2'b00;
    pc_next_int = pc;
    pc_en_int   = 1'b0;
    fill        = 1'b0;

    unique case (state_q)
      ST_IDLE: req_int = ~hv_q[fa_q[0]];
      ST_REQ:  req_int = 1'b1;
      ST_DROP: begin
        // The stale request must keep its original address until acked.
        req_int  = 1'b1;
        addr_int = addr_q;
      end
      default: req_int = 1'b0;
    endcase

    // Data from a request made stale by a redirect (earlier or this cycle)
    // never reaches the IR.
    fill = req_int & mem_ack & (state_q != ST_DROP) & ~redirect;

    if (redirect) begin
      pc_next_int = {redir_word[0], redirect_addr[2:0]};
      pc_en_int   = 1'b1;
      hv_d        = 2'b00;
      fa_d        = redir_word;
      state_d     = (req_int && !mem_ack) ? ST_DROP : ST_IDLE;
    end else begin
      if (issue_int) begin
        pc_next_int = pc + {1'b0, cur_len} + 4'd1;
        pc_en_int   = 1'b1;
        // Reaching the end of the half means it is fully consumed.
        if (end_nib >= 4'd8) hv_d[pc[3]] = 1'b0;
      end

      if (fill) begin
        be_int[fa_q[0]] = 1'b1;
        hv_d[fa_q[0]]   = 1'b1;
        fa_d            = fa_q + 1'b1;
      end

      unique case (state_q)
        ST_IDLE, ST_REQ: begin
          if (fill)         state_d = hv_d[fa_d[0]] ? ST_IDLE : ST_REQ;
          else if (req_int) state_d = ST_REQ;
        end
        ST_DROP: if (mem_ack) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    addr_d = addr_int;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hv_q    <= 2'b00;
      fa_q    <= RESET_ADDR;
      addr_q  <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      hv_q    <= hv_d;
      fa_q    <= fa_d;
      addr_q  <= addr_d;
    end
  end

  assign ir_next  = {mem_rdata, mem_rdata};
  assign mem_req  = reset ? 1'b0       : req_int;
  assign mem_addr = reset ? RESET_ADDR : addr_int;
  assign ir_be    = reset ? 2'b00      : be_int;
  assign pc_next  = reset ? 4'h0       : pc_next_int;
  assign pc_en    = reset ? 1'b0       : pc_en_int;
  assign issue    = reset ? 1'b0       : issue_int;

`ifdef IR_FETCH_PERF_EN
  logic [15:0] perf_q;

  // A bubble: execution could take an instruction but none is ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 16'h0000;
    end else if (~avail & ~stall & ~redirect & (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'h0001;
    end
  end

  assign perf_bubbles = perf_q;
`endif

endmodule

// File: tb/tb_ir_fetch.sv
// -----------------------------------------------------------------------------
// tb_ir_fetch
//   Self-checking bench for ir_fetch. A zero-wait memory model (ack gated by
//   ack_en) returns {~addr, addr} for each word. Every fill the bench expects
//   is pushed to a scoreboard queue; a negedge monitor pops and compares each
//   IR write. Issue/pc/redirect behaviour is checked inline in each task.
// -----------------------------------------------------------------------------
module tb_ir_fetch;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [63:0]       ir_next;
  logic [1:0]        ir_be;
  logic [3:0]        pc;
  logic [2:0]        cur_len;
  logic              stall;
  logic              redirect;
  logic [ADDR_W+2:0] redirect_addr;
  logic [3:0]        pc_next;
  logic              pc_en;
  logic              issue;
`ifdef IR_FETCH_PERF_EN
  logic [15:0]       perf_bubbles;
`endif

  logic ack_en;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        be;
  } fill_t;

  fill_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return {~a, a};
  endfunction

  // Zero-wait memory: acks in the same cycle as the request when enabled.
  assign mem_ack   = ack_en & mem_req;
  assign mem_rdata = word_of(mem_addr);

  ir_fetch #(.ADDR_W(ADDR_W), .RESET_ADDR(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir_next       (ir_next),
    .ir_be         (ir_be),
    .pc            (pc),
    .cur_len       (cur_len),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .pc_next       (pc_next),
    .pc_en         (pc_en),
    .issue         (issue)
`ifdef IR_FETCH_PERF_EN
    ,
    .perf_bubbles  (perf_bubbles)
`endif
  );

  // Scoreboard monitor: every IR write must match the next expected fill.
  always @(negedge clk) begin
    if (!reset && ir_be !== 2'b00) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL fill_unexpected: ir_be=%b addr=%h, expected no fill", ir_be, mem_addr);
      end else begin
        fill_t exp;
        exp = sb.pop_front();
        if (mem_addr !== exp.addr || ir_be !== exp.be ||
            ir_next !== {word_of(exp.addr), word_of(exp.addr)}) begin
          fails++;
          $display("FAIL fill_data: addr=%h be=%b data=%h, expected addr=%h be=%b data=%h",
                   mem_addr, ir_be, ir_next, exp.addr, exp.be,
                   {word_of(exp.addr), word_of(exp.addr)});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [1:0] be);
    fill_t f;
    f.addr = a;
    f.be   = be;
    sb.push_back(f);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({mem_req, ir_be, pc_en, issue, pc_next} !== 9'b0 || mem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL reset_outputs: req=%b be=%b pc_en=%b issue=%b pc_next=%h addr=%h, expected all 0",
               mem_req, ir_be, pc_en, issue, pc_next, mem_addr);
    end
`ifdef IR_FETCH_PERF_EN
    tests++;
    if (perf_bubbles !== 16'h0000) begin
      fails++;
      $display("FAIL reset_perf: got %h expected 0000", perf_bubbles);
    end
`endif
    reset = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL reset_first_req: req=%b addr=%h, expected req=1 addr=0000", mem_req, mem_addr);
    end
  endtask

  task automatic test_fill();
    push(16'h0000, 2'b01);
    push(16'h0001, 2'b10);
    ack_en = 1'b1;
    #1;
    tests++;
    if (ir_be !== 2'b01) begin
      fails++;
      $display("FAIL fill_first_be: got %b expected 01", ir_be);
    end
    step();
    tests++;
    if (mem_addr !== 16'h0001 || ir_be !== 2'b10) begin
      fails++;
      $display("FAIL fill_second: addr=%h be=%b expected addr=0001 be=10", mem_addr, ir_be);
    end
    step();
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL fill_both_valid_idle: req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_issue_full();
    pc = 4'd0; cur_len = 3'd7; stall = 1'b0;
    #1;
    tests++;
    if (issue !== 1'b1 || pc_en !== 1'b1 || pc_next !== 4'h8) begin
      fails++;
      $display("FAIL issue_full: issue=%b pc_en=%b pc_next=%h expected 1 1 8", issue, pc_en, pc_next);
    end
    push(16'h0002, 2'b01);
    step();
    stall = 1'b1; pc = 4'd8;
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0002 || ir_be !== 2'b01) begin
      fails++;
      $display("FAIL issue_full_refill: req=%b addr=%h be=%b expected 1 0002 01", mem_req, mem_addr, ir_be);
    end
    step();
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL issue_full_settled: req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_span();
    ack_en = 1'b0;
    pc = 4'd8; cur_len = 3'd7; stall = 1'b0;
    #1;
    tests++;
    if (issue !== 1'b1 || pc_next !== 4'h0) begin
      fails++;
      $display("FAIL span_free_hi: issue=%b pc_next=%h expected 1 0", issue, pc_next);
    end
    step();
    stall = 1'b1; pc = 4'd6; cur_len = 3'd3;
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0003) begin
      fails++;
      $display("FAIL span_req: req=%b addr=%h expected 1 0003", mem_req, mem_addr);
    end
    stall = 1'b0;
    #1;
    tests++;
    if (issue !== 1'b0 || pc_en !== 1'b0 || pc_next !== 4'h6) begin
      fails++;
      $display("FAIL span_no_issue: issue=%b pc_en=%b pc_next=%h expected 0 0 6", issue, pc_en, pc_next);
    end
    step();
    push(16'h0003, 2'b10);
    ack_en = 1'b1;
    #1;
    tests++;
    if (ir_be !== 2'b10 || issue !== 1'b0) begin
      fails++;
      $display("FAIL span_ack: be=%b issue=%b expected 10 0", ir_be, issue);
    end
    push(16'h0004, 2'b01);
    step();
    tests++;
    if (issue !== 1'b1 || pc_next !== 4'hA || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL span_issue: issue=%b pc_next=%h req=%b expected 1 a 0", issue, pc_next, mem_req);
    end
    step();
    stall = 1'b1; pc = 4'd10;
    #1;
    tests++;
    if (mem_addr !== 16'h0004 || ir_be !== 2'b01) begin
      fails++;
      $display("FAIL span_refill: addr=%h be=%b expected 0004 01", mem_addr, ir_be);
    end
    step();
  endtask

  task automatic test_redirect();
    ack_en = 1'b0;
    pc = 4'd8; cur_len = 3'd7; stall = 1'b0;
    step();
    stall = 1'b1; pc = 4'd0;
    step();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin
      fails++;
      $display("FAIL redir_pending: req=%b addr=%h expected 1 0005", mem_req, mem_addr);
    end
    redirect = 1'b1; redirect_addr = 19'h0002B;
    #1;
    tests++;
    if (pc_next !== 4'hB || pc_en !== 1'b1 || issue !== 1'b0 || ir_be !== 2'b00) begin
      fails++;
      $display("FAIL redir_pc: pc_next=%h pc_en=%b issue=%b be=%b expected b 1 0 00",
               pc_next, pc_en, issue, ir_be);
    end
    step();
    redirect = 1'b0;
    ack_en = 1'b1;
    #1;
    tests++;
    if (mem_req !== 1'b1 || ir_be !== 2'b00) begin
      fails++;
      $display("FAIL redir_drop: req=%b be=%b expected 1 00", mem_req, ir_be);
    end
    push(16'h0005, 2'b10);
    push(16'h0006, 2'b01);
    step();
    tests++;
    if (mem_addr !== 16'h0005 || ir_be !== 2'b10) begin
      fails++;
      $display("FAIL redir_new_req: addr=%h be=%b expected 0005 10", mem_addr, ir_be);
    end
    step();
    step();
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL redir_settled: req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_redirect_latency();
    pc = 4'd0; cur_len = 3'd1; stall = 1'b0;
    redirect = 1'b1; redirect_addr = {16'h0020, 3'd2};
    #1;
    tests++;
    if (pc_next !== 4'h2 || pc_en !== 1'b1 || issue !== 1'b0) begin
      fails++;
      $display("FAIL lat_redirect: pc_next=%h pc_en=%b issue=%b expected 2 1 0", pc_next, pc_en, issue);
    end
    push(16'h0020, 2'b01);
    push(16'h0021, 2'b10);
    step();
    redirect = 1'b0; pc = 4'd2;
    #1;
    tests++;
    if (issue !== 1'b0 || mem_addr !== 16'h0020) begin
      fails++;
      $display("FAIL lat_cycle1: issue=%b addr=%h expected 0 0020", issue, mem_addr);
    end
    step();
    tests++;
    if (issue !== 1'b1 || pc_next !== 4'h4) begin
      fails++;
      $display("FAIL lat_cycle2: issue=%b pc_next=%h expected 1 4", issue, pc_next);
    end
    stall = 1'b1;
    step();
  endtask

  task automatic test_stall_redirect();
    pc = 4'd0; cur_len = 3'd3; stall = 1'b1;
    #1;
    tests++;
    if (issue !== 1'b0 || pc_en !== 1'b0 || pc_next !== 4'h0) begin
      fails++;
      $display("FAIL stall_hold: issue=%b pc_en=%b pc_next=%h expected 0 0 0", issue, pc_en, pc_next);
    end
    pc = 4'd2; cur_len = 3'd5; stall = 1'b0;
    #1;
    tests++;
    if (issue !== 1'b1 || pc_next !== 4'h8) begin
      fails++;
      $display("FAIL stall_release: issue=%b pc_next=%h expected 1 8", issue, pc_next);
    end
    step();
    stall = 1'b1; pc = 4'd8;
    redirect = 1'b1; redirect_addr = {16'h0040, 3'd5};
    #1;
    tests++;
    if (pc_next !== 4'h5 || pc_en !== 1'b1 || mem_req !== 1'b1 || ir_be !== 2'b00) begin
      fails++;
      $display("FAIL stall_redirect_ack: pc_next=%h pc_en=%b req=%b be=%b expected 5 1 1 00",
               pc_next, pc_en, mem_req, ir_be);
    end
    push(16'h0040, 2'b01);
    push(16'h0041, 2'b10);
    step();
    redirect = 1'b0;
    step();
    step();
  endtask

  task automatic test_wrap();
    pc = 4'd14; cur_len = 3'd2; stall = 1'b0;
    #1;
    tests++;
    if (issue !== 1'b1 || pc_next !== 4'h1) begin
      fails++;
      $display("FAIL wrap_pc: issue=%b pc_next=%h expected 1 1", issue, pc_next);
    end
    step();
    cur_len = 3'd0;
    #1;
    tests++;
    if (issue !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL wrap_hi_cleared: issue=%b req=%b expected 0 0", issue, mem_req);
    end
    pc = 4'd1;
    #1;
    tests++;
    if (issue !== 1'b1 || pc_next !== 4'h2) begin
      fails++;
      $display("FAIL wrap_lo_kept: issue=%b pc_next=%h expected 1 2", issue, pc_next);
    end
    stall = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; ack_en = 1'b0;
    pc = 4'd0; cur_len = 3'd0; stall = 1'b1;
    redirect = 1'b0; redirect_addr = '0;

    test_reset();
    test_fill();
    test_issue_full();
    test_span();
    test_redirect();
    test_redirect_latency();
    test_stall_redirect();
    test_wrap();

    step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drained: %0d fills outstanding, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
